gate_resp_checker: RTL and testbench
====================================

# gate_resp_checker

Hardware response analyzer for 2-input XNOR gate blocks. It consumes a stream of observed vectors {a, b, y} over a valid/ready handshake and compares each y against the golden XNOR of a and b. It counts passes and fails, captures the first failing vector, and raises a done/pass verdict after a programmed number of vectors. It sits on the checking side of the gate-test path: stimulus comes from a generator or scan source, and the verdict goes to a status register or LED.

## Interface
Parameters:
- CNT_W, default 8: width of the vector-count, pass-count and fail-count fields.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request: clears the results and enters RUN.
- num_vec  in  CNT_W  number of vectors expected; sampled on start.
- in_valid  in  1  producer has a vector.
- in_ready  out  1  checker accepts a vector.
- in_a, in_b  in  1 each  stimulus applied to the gate under test.
- in_y  in  1  observed gate output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  verdict; meaningful only while done=1.
- pass_cnt, fail_cnt  out  CNT_W each  result counters.
- first_fail  out  3  {a, b, y} of the first mismatching vector.
- first_fail_vld  out  1  first_fail holds a captured vector.
- cov  out  4  input-combination coverage; present only with the macro defined.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the accepted-vector count reaches the latched num_vec.
  - DONE -> RUN on start.
  - Any state -> IDLE only on reset.
- A transfer occurs when in_valid && in_ready.
  - in_ready = 1 only in RUN.
  - in_a, in_b and in_y are sampled only on a transfer.
- Expected value: exp = ~(in_a ^ in_b).
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments. If first_fail_vld = 0, capture {in_a, in_b, in_y} into first_fail and set first_fail_vld.
- Counters saturate at 2^CNT_W - 1. The internal accepted-vector count does not saturate; it is compared against num_vec, which is at most 2^CNT_W - 1.
- pass = done && (fail_cnt == 0). With the macro defined, pass additionally requires cov == 4'hF.
- start while in RUN or DONE restarts the run:
  - clears the counters, first_fail, first_fail_vld and cov;
  - re-latches num_vec;
  - enters RUN.
- If start and a transfer coincide, start wins: the beat is discarded and not counted.
- num_vec = 0: start leads to RUN for one cycle with in_ready forced to 0, then DONE, with pass = 1. With the macro defined, pass = 0 because coverage is empty.

## Timing
- Reset values: busy = 0, done = 0, pass = 0, in_ready = 0, pass_cnt = 0, fail_cnt = 0, first_fail = 3'b000, first_fail_vld = 0, cov = 4'h0. State = IDLE.
- The cycle after start: busy = 1 and in_ready = 1.
- Counters and first_fail update one cycle after the transfer edge.
- Last vector (the num_vec-th transfer) on edge N:
  - edge N+1: done = 1, busy = 0, in_ready = 0, pass valid;
  - the in_ready deassertion happens on the same edge as the final counter update.
- Gaps in in_valid stall the checker indefinitely; there is no timeout.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. No partial results are kept.

## Configuration
- Macro: GATE_CHK_COVERAGE_EN.
- Defined:
  - the cov output exists;
  - cov[{a,b}] sets on each accepted vector, whether it matched or not;
  - pass requires full coverage (cov == 4'hF).
- Undefined:
  - no cov port and no coverage register;
  - pass depends on fail_cnt only.

## Structure
- Package gate_chk_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - packed struct vec_t {a, b, y};
  - constant NUM_COMBOS = 4.
- One sub-module: gate_ref_xnor, the combinational golden model (a, b -> exp). It is swappable for other gate types.

## Test plan
- start, num_vec = 4; feed 00/1, 01/0, 10/0, 11/1 back-to-back -> pass_cnt = 4, fail_cnt = 0, done = 1 and pass = 1 one cycle after the last beat.
- Same sequence but 01 with y = 1 -> fail_cnt = 1, first_fail = 3'b011, first_fail_vld = 1, pass = 0.
- in_valid toggling 1/0 with num_vec = 4 -> still exactly 4 counted; done lands one cycle after the 4th transfer.
- start with num_vec = 0 -> done = 1 after two cycles, no vectors accepted, pass = 1 (or 0 with the macro defined).
- rst_n pulled low after 2 of 4 vectors -> all outputs return to their reset values; a following start runs cleanly to pass_cnt = 4.
- Macro defined; 4 correct vectors all equal to 00/1 -> cov = 4'h1, fail_cnt = 0, pass = 0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and constants for the gate response checker
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic a;
        logic b;
        logic y;
    } vec_t;

    localparam int NUM_COMBOS = 4;

endpackage

// File: rtl/gate_ref_xnor.sv
// gate_ref_xnor: combinational golden model of a 2-input XNOR gate
//   a, b : gate inputs
//   exp  : expected gate output
module gate_ref_xnor (
    input  logic a,
    input  logic b,
    output logic exp
);

    assign exp = ~(a ^ b);

endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks observed 2-input gate responses against a golden model
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, num_vec      : restart request and number of vectors to check
//   in_valid, in_ready  : vector handshake
//   in_a, in_b, in_y    : stimulus and observed output of the gate under test
//   busy, done, pass    : run status and verdict (pass meaningful while done)
//   pass_cnt, fail_cnt  : saturating result counters
//   first_fail(_vld)    : {a, b, y} of the first mismatching vector
//   cov                 : input-combination coverage, only with GATE_CHK_COVERAGE_EN
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [2:0]       first_fail,
    output logic             first_fail_vld
`ifdef GATE_CHK_COVERAGE_EN
    ,
    output logic [NUM_COMBOS-1:0] cov
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] nv_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_nxt;
    logic             xfer;
    logic             exp_y;
    vec_t             vec;

    gate_ref_xnor u_ref (
        .a   (in_a),
        .b   (in_b),
        .exp (exp_y)
    );

    assign vec      = '{a: in_a, b: in_b, y: in_y};
    // in_ready stays low in the degenerate num_vec = 0 run
    assign in_ready = (state == RUN) && (acc_q != nv_q);
    // a coinciding start discards the beat
    assign xfer     = in_valid && in_ready && !start;
    assign acc_nxt  = acc_q + CNT_W'(xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: begin
                busy      = 1'b1;
                state_nxt = (acc_nxt == nv_q) ? DONE : RUN;
            end
            DONE:    done      = 1'b1;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nv_q           <= '0;
            acc_q          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail     <= 3'b000;
            first_fail_vld <= 1'b0;
        end else if (start) begin
            nv_q           <= num_vec;
            acc_q          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail     <= 3'b000;
            first_fail_vld <= 1'b0;
        end else if (xfer) begin
            acc_q <= acc_nxt;
            if (in_y == exp_y) begin
                pass_cnt <= (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + 1'b1;
            end else begin
                fail_cnt <= (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail     <= vec;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

`ifdef GATE_CHK_COVERAGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cov <= '0;
        else if (start) cov <= '0;
        else if (xfer)  cov[{in_a, in_b}] <= 1'b1;
    end

    assign pass = done && (fail_cnt == '0) && (cov == 4'hF);
`else
    assign pass = done && (fail_cnt == '0);
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: randomized self-checking bench for gate_resp_checker
module tb_gate_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_vec = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_a = 1'b0, in_b = 1'b0, in_y = 1'b0;
    logic       in_ready, busy, done, pass, first_fail_vld;
    logic [7:0] pass_cnt, fail_cnt;
    logic [2:0] first_fail;
`ifdef GATE_CHK_COVERAGE_EN
    logic [3:0] cov;
`endif

    int checks = 0;
    int failures = 0;

    int         m_pass, m_fail;
    logic [2:0] m_ff;
    logic       m_ffv;
    logic [3:0] m_cov;
    logic [2:0] vq[$];

    gate_resp_checker #(.CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_y           (in_y),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
`ifdef GATE_CHK_COVERAGE_EN
        ,
        .cov            (cov)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_verdict();
`ifdef GATE_CHK_COVERAGE_EN
        return (m_fail == 0) && (m_cov == 4'hF);
`else
        return m_fail == 0;
`endif
    endfunction

    task automatic model_clear();
        m_pass = 0;
        m_fail = 0;
        m_ff   = 3'b000;
        m_ffv  = 1'b0;
        m_cov  = 4'h0;
    endtask

    task automatic model_beat(input logic [2:0] v);
        logic a, b, y;
        {a, b, y} = v;
        if (y == (a == b)) m_pass++;
        else begin
            m_fail++;
            if (!m_ffv) begin
                m_ff  = v;
                m_ffv = 1'b1;
            end
        end
        m_cov[{a, b}] = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_pcnt"}, pass_cnt, 0);
        check({tag, "_fcnt"}, fail_cnt, 0);
        check({tag, "_ff"}, first_fail, 0);
        check({tag, "_ffv"}, first_fail_vld, 0);
`ifdef GATE_CHK_COVERAGE_EN
        check({tag, "_cov"}, cov, 0);
`endif
    endtask

    task automatic check_results(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_pcnt"}, pass_cnt, m_pass);
        check({tag, "_fcnt"}, fail_cnt, m_fail);
        check({tag, "_ff"}, first_fail, m_ff);
        check({tag, "_ffv"}, first_fail_vld, m_ffv);
        check({tag, "_pass"}, pass, m_verdict());
`ifdef GATE_CHK_COVERAGE_EN
        check({tag, "_cov"}, cov, m_cov);
`endif
    endtask

    // call at a negedge; returns at the negedge after the start edge
    task automatic do_start(input string tag, input logic [7:0] n);
        start   = 1'b1;
        num_vec = n;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check({tag, "_st_busy"}, busy, 1);
        check({tag, "_st_rdy"}, in_ready, n != 0);
        check({tag, "_st_pcnt"}, pass_cnt, 0);
        check({tag, "_st_ffv"}, first_fail_vld, 0);
    endtask

    task automatic feed(input string tag, input int n, input bit toggle, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        bit ph = 1'b0;
        while (idx < n && cyc < 5000) begin
            check({tag, "_run_busy"}, busy, 1);
            in_valid = toggle ? ph : ($urandom_range(99) >= gap_pct);
            ph = ~ph;
            {in_a, in_b, in_y} = vq[idx];
            if (in_valid && in_ready) begin
                model_beat(vq[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, idx, n);
    endtask

    task automatic fill_rand(input int n, input int err_pct);
        logic a, b;
        vq.delete();
        for (int i = 0; i < n; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            vq.push_back({a, b, ~(a ^ b) ^ ($urandom_range(99) < err_pct)});
        end
    endtask

    initial begin
        model_clear();
        #1;
        check_reset("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle");

        vq = '{3'b001, 3'b010, 3'b100, 3'b111};
        do_start("t1", 4);
        feed("t1", 4, 1'b0, 0);
        check_results("t1");
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_hold_pcnt", pass_cnt, m_pass);
        check("t1_hold_done", done, 1);

        vq = '{3'b001, 3'b011, 3'b100, 3'b111};
        do_start("t2", 4);
        feed("t2", 4, 1'b0, 0);
        check_results("t2");

        vq = '{3'b001, 3'b010, 3'b100, 3'b111};
        do_start("t3", 4);
        feed("t3", 4, 1'b1, 0);
        check_results("t3");

        do_start("t4", 0);
        @(negedge clk);
        check_results("t4");

        fill_rand(4, 0);
        do_start("t5", 4);
        feed("t5", 2, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset("t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_reset("t5_idle");
        fill_rand(4, 0);
        do_start("t5b", 4);
        feed("t5b", 4, 1'b0, 30);
        check_results("t5b");
        check("t5b_pcnt4", pass_cnt, 4);

        vq = '{3'b001, 3'b001, 3'b001, 3'b001};
        do_start("t6", 4);
        feed("t6", 4, 1'b0, 0);
        check_results("t6");

        fill_rand(4, 50);
        do_start("t7", 4);
        feed("t7", 2, 1'b0, 0);
        in_valid = 1'b1;
        {in_a, in_b, in_y} = 3'b010;
        do_start("t7c", 3);
        check("t7c_fcnt", fail_cnt, 0);
        fill_rand(3, 30);
        feed("t7c", 3, 1'b0, 20);
        check_results("t7c");

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(12, 1);
            fill_rand(n, (r % 2 == 0) ? 0 : 25);
            do_start("rnd", 8'(n));
            feed("rnd", n, 1'b0, 30);
            check_results("rnd");
        end

        fill_rand(255, 40);
        do_start("big", 255);
        feed("big", 255, 1'b0, 10);
        check_results("big");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
